// File: rtl/alu_control.sv
// alu_control: registered ALU operation select decoded from ALUop and the R-type funct field
//   clk           rising-edge clock
//   rst           asynchronous active-high reset, clears alu_ctr to 000
//   ALUop         operation class from main control
//   function_code instruction funct field, only used when ALUop is 111
//   alu_ctr       ALU operation select, valid one cycle after its inputs are sampled
module alu_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ALUop,
    input  logic [5:0] function_code,
    output logic [2:0] alu_ctr
);
    logic [2:0] w_rtype;
    logic [2:0] w_dec;
    logic [2:0] r_alu_ctr;
    // Funct codes in the low octet pass their low bits straight through; everything else adds
    always_comb begin
        w_rtype = (function_code[5:3] == 3'b000) ? function_code[2:0] : 3'b010;
        w_dec   = (ALUop == 3'b111) ? w_rtype :
                  (ALUop == 3'b000) ? 3'b000  :
                  (ALUop == 3'b001) ? 3'b001  :
                  (ALUop == 3'b100) ? 3'b111  :
                  (ALUop == 3'b110) ? 3'b110  : 3'b010;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_alu_ctr <= 3'b000;
        else     r_alu_ctr <= w_dec;
    end
    assign alu_ctr = r_alu_ctr;
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: randomized and directed check of alu_control against a table-driven model
module tb_alu_control;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ALUop = 3'b000;
    logic [5:0] function_code = 6'b000000;
    logic [2:0] alu_ctr;
    int n_vec = 0;
    int n_err = 0;

    alu_control dut (
        .clk(clk),
        .rst(rst),
        .ALUop(ALUop),
        .function_code(function_code),
        .alu_ctr(alu_ctr)
    );

    always #5 clk = ~clk;

    // Result per ALUop class; index 7 is replaced by the funct decode
    logic [2:0] op_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd7, 3'd2, 3'd6, 3'd0};

    function automatic logic [2:0] model(input logic [2:0] op, input logic [5:0] f);
        int fi;
        fi = int'(f);
        if (op != 3'd7) return op_tab[op];
        return (fi < 8) ? 3'(fi) : 3'd2;
    endfunction

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic apply(input string tag, input logic [2:0] op, input logic [5:0] f);
        @(negedge clk);
        ALUop = op;
        function_code = f;
        @(posedge clk);
        #1;
        chk(tag, alu_ctr, model(op, f));
    endtask

    initial begin
        #1;
        chk("reset_state", alu_ctr, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        apply("rtype_add", 3'b111, 6'b000010);
        apply("rtype_slt", 3'b111, 6'b000111);
        // asynchronous reset between edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst", alu_ctr, 3'b000);
        @(posedge clk);
        #1 chk("rst_hold", alu_ctr, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_release_wait", alu_ctr, 3'b000);
        @(posedge clk);
        #1 chk("rst_release_load", alu_ctr, 3'b111);
        apply("addi", 3'b101, 6'b000000);
        apply("subi", 3'b110, 6'b000000);
        apply("andi", 3'b000, 6'b000000);
        apply("ori", 3'b001, 6'b111111);
        apply("slti", 3'b100, 6'b000011);
        apply("unused2", 3'b010, 6'b000110);
        apply("unused3", 3'b011, 6'b000001);
        apply("funct_ignored", 3'b110, 6'b000001);
        apply("rtype_upper", 3'b111, 6'b101010);
        apply("rtype_or", 3'b111, 6'b000001);
        apply("rtype_and", 3'b111, 6'b000000);
        // latency: output holds until the next rising edge
        @(negedge clk);
        ALUop = 3'b110;
        #1 chk("latency_hold", alu_ctr, 3'b000);
        @(posedge clk);
        #1 chk("latency_load", alu_ctr, 3'b110);
        for (int i = 0; i < 300; i++) begin
            logic [2:0] op;
            logic [5:0] f;
            op = 3'($urandom_range(0, 7));
            f  = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            apply("random", op, f);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
